// File: rtl/sram_like_pkg.sv
// Shared types and constants for the SRAM-like responder: access sizes, the
// response-queue entry and the LFSR used by the random-delay build option.
package sram_like_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_e;

   localparam int TIMER_W = 8;

   typedef struct packed {
      logic               is_wr;
      logic [31:0]        data;
      logic [TIMER_W-1:0] timer;
   } resp_entry_t;

   // Polynomial x^8 + x^6 + x^5 + x^4 + 1 (taps 8,6,5,4 -> bits 7,5,4,3).
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   function automatic logic [7:0] lfsr_next(input logic [7:0] state);
      return {state[6:0], ^(state & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/sram_like_resp_if.sv
// SRAM-like data bus between the core (master) and a memory responder (slave).
interface sram_like_resp_if;

   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );

endinterface

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue: DEPTH-entry ring buffer whose entries each carry a
// countdown timer that decrements every cycle and saturates at zero.
module resp_fifo
   import sram_like_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  resp_entry_t                push_entry,
   input  logic                       pop,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output resp_entry_t                head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   resp_entry_t        entries [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // NOTE: two non-blocking writes to one slot in a block resolve last-wins, so
   // a freshly pushed entry keeps its full starting timer.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (entries[i].timer != '0) begin
            entries[i].timer <= entries[i].timer - 1'b1;
         end
      end
      if (push) begin
         entries[wr_ptr] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head = entries[rd_ptr];

   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W == 0);

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like memory responder: word RAM with in-order, fixed-latency responses.
// Build option SRAM_LIKE_RESP_RANDOM_DELAY_EN adds LFSR-driven backpressure and jitter.
module sram_like_resp
   import sram_like_pkg::*;
#(
   parameter int         MEM_AW    = 12,
   parameter int         DEPTH     = 2,
   parameter int         LATENCY   = 1,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   sram_like_resp_if.slave   bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [31:0]       mem [2**MEM_AW];
   logic [MEM_AW-1:0] index;
   logic              accept;
   logic              gate;
   logic [1:0]        extra;
   logic [CNT_W-1:0]  count;
   resp_entry_t       head;
   resp_entry_t       push_entry;
   logic              pop;

`ifdef SRAM_LIKE_RESP_RANDOM_DELAY_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk) begin
      if (reset) lfsr <= LFSR_SEED;
      else       lfsr <= lfsr_next(lfsr);
   end

   assign gate  = lfsr[0];
   assign extra = lfsr[2:1];
`else
   assign gate  = 1'b1;
   assign extra = 2'd0;
`endif

   assign index  = bus.addr[MEM_AW+1:2];
   assign accept = bus.req && bus.addr_ok;

   // Flow control looks only at registered occupancy, so a pop never frees a slot early.
   assign bus.addr_ok = !reset && (count < CNT_W'(DEPTH)) && gate;
   assign bus.data_ok = !reset && (count != '0) && (head.timer == '0);
   assign bus.rdata   = (bus.data_ok && !head.is_wr) ? head.data : '0;
   assign pop         = bus.data_ok;

   // NOTE: every field gets a value on every path, so no latch is inferred.
   always_comb begin
      push_entry.is_wr = bus.wr;
      push_entry.data  = bus.wr ? 32'd0 : mem[index];
      push_entry.timer = TIMER_W'(LATENCY - 1) + TIMER_W'(extra);
   end

   // NOTE: the RAM array is deliberately left out of reset; only control state clears.
   always_ff @(posedge clk) begin
      if (accept && bus.wr) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.wstrb[i]) mem[index][8*i +: 8] <= bus.wdata[8*i +: 8];
         end
      end
   end

   resp_fifo #(
      .DEPTH (DEPTH)
   ) u_resp_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (accept),
      .push_entry (push_entry),
      .pop        (pop),
      .count      (count),
      .head       (head)
   );

   // Size and the sub-word/upper address bits carry no meaning for this model.
   logic unused_bus_bits;
   assign unused_bus_bits = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: LATENCY=1 instance with a scoreboard, LATENCY=4
// instance for backpressure, mid-flight reset and memory retention.
`timescale 1ns/1ps
module tb_sram_like_resp;
   import sram_like_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1 = 1'b1;
   logic rst4 = 1'b1;

   sram_like_resp_if bus1();
   sram_like_resp_if bus4();

   sram_like_resp #(.MEM_AW(12), .DEPTH(2), .LATENCY(1), .LFSR_SEED(8'hA5)) u_dut1 (
      .clk(clk), .reset(rst1), .bus(bus1.slave));
   sram_like_resp #(.MEM_AW(12), .DEPTH(2), .LATENCY(4), .LFSR_SEED(8'hA5)) u_dut4 (
      .clk(clk), .reset(rst4), .bus(bus4.slave));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard for the LATENCY=1 instance.
   logic [31:0] model_mem [int];
   logic [31:0] exp_q [$];
   logic        acc_pending = 1'b0;
   logic        acc_prev    = 1'b0;
   bit          mon_en      = 1'b0;
   int          acc1 = 0;
   int          dok1 = 0;
   logic [31:0] last_rd1 = '0;

   always @(posedge clk) acc_prev <= acc_pending;

   always @(negedge clk) begin
      if (mon_en) begin
         check("dok_timing", 32'(bus1.data_ok), 32'(acc_prev));
         if (bus1.data_ok) begin
            dok1++;
            last_rd1 = bus1.rdata;
            if (exp_q.size() == 0) begin
               check("dok_spurious", 32'd1, 32'd0);
            end else begin
               check("rdata", bus1.rdata, exp_q.pop_front());
            end
         end
      end
   end

   task automatic issue1(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
      int          idx;
      logic [31:0] cur;
      idx = int'(a[13:2]);
      @(negedge clk);
      bus1.req   = 1'b1;
      bus1.wr    = w;
      bus1.addr  = a;
      bus1.wdata = d;
      bus1.wstrb = s;
      bus1.size  = SIZE_W;
      #1;
      check("aok1", 32'(bus1.addr_ok), 32'd1);
      if (bus1.addr_ok) begin
         cur = model_mem.exists(idx) ? model_mem[idx] : 32'd0;
         if (w) begin
            for (int i = 0; i < 4; i++) if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
            model_mem[idx] = cur;
            exp_q.push_back(32'd0);
         end else begin
            exp_q.push_back(cur);
         end
         acc_pending = 1'b1;
         acc1++;
      end
      @(posedge clk);
      #1;
      acc_pending = 1'b0;
      bus1.req    = 1'b0;
   endtask

   bit exp_aok [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
   bit exp_dok [11] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0};

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   acc4;
      int   lat;
      bit   got;
      logic [31:0] a;

      bus4.req = 1'b0; bus4.wr = 1'b0; bus4.size = SIZE_W; bus4.wstrb = '0;
      bus4.addr = '0;  bus4.wdata = '0;

      // Reset held with a pending write request.
      bus1.req = 1'b1; bus1.wr = 1'b1; bus1.size = SIZE_W; bus1.wstrb = 4'hF;
      bus1.addr = 32'h0; bus1.wdata = 32'hFFFF_FFFF;
      repeat (3) begin
         @(negedge clk);
         check("rst_aok",   32'(bus1.addr_ok), 32'd0);
         check("rst_dok",   32'(bus1.data_ok), 32'd0);
         check("rst_rdata", bus1.rdata, 32'd0);
      end
      bus1.req = 1'b0;
      rst1 = 1'b0;
      rst4 = 1'b0;
      @(posedge clk);
      #1;
      check("aok_after_rst", 32'(bus1.addr_ok), 32'd1);
      mon_en = 1'b1;

      // Write then read the same word: responses on consecutive cycles.
      issue1(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
      issue1(1'b0, 32'h100, 32'h0, 4'h0);
      @(negedge clk);
      #1;
      check("wr_rd_data", last_rd1, 32'hDEAD_BEEF);
      repeat (2) @(negedge clk);

      // Byte strobe merges a single lane.
      issue1(1'b1, 32'h200, 32'h1122_3344, 4'hF);
      issue1(1'b1, 32'h200, 32'hAAAA_AAAA, 4'b0100);
      issue1(1'b0, 32'h202, 32'h0, 4'h0);
      @(negedge clk);
      #1;
      check("strobe_data", last_rd1, 32'h11AA_3344);

      // Random traffic over a small pool, with aliased upper and sub-word address bits.
      for (int w = 0; w < 8; w++) issue1(1'b1, 32'h400 + 32'(w*4), $urandom, 4'hF);
      for (int n = 0; n < 60; n++) begin
         a = 32'h400 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
         a = a | ($urandom & 32'hFFFF_C000);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         issue1(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end
      repeat (3) @(negedge clk);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      check("dok_count",  32'(dok1), 32'(acc1));

      // Backpressure on the LATENCY=4, DEPTH=2 instance.
      acc4 = 0;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         bus4.req   = (acc4 < 3);
         bus4.wr    = 1'b1;
         bus4.wstrb = 4'hF;
         bus4.addr  = 32'h300 + 32'(acc4 * 4);
         bus4.wdata = 32'h0BAD_0300 + 32'(acc4 * 4);
         #1;
         check($sformatf("bp_aok_%0d", k), 32'(bus4.addr_ok), 32'(exp_aok[k]));
         check($sformatf("bp_dok_%0d", k), 32'(bus4.data_ok), 32'(exp_dok[k]));
         if (bus4.data_ok) check("bp_rdata", bus4.rdata, 32'd0);
         if (bus4.req && bus4.addr_ok) acc4++;
      end
      bus4.req = 1'b0;
      check("bp_accepts", 32'(acc4), 32'd3);

      // Reset one cycle after accepting a read: its response is dropped.
      @(negedge clk);
      bus4.req = 1'b1; bus4.wr = 1'b0; bus4.addr = 32'h304;
      #1;
      check("mf_aok", 32'(bus4.addr_ok), 32'd1);
      @(negedge clk);
      bus4.req = 1'b0;
      @(negedge clk);
      rst4 = 1'b1;
      @(negedge clk);
      rst4 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("mf_no_dok", 32'(bus4.data_ok), 32'd0);
      end

      // Memory survives reset; read returns after exactly four cycles.
      @(negedge clk);
      bus4.req = 1'b1; bus4.wr = 1'b0; bus4.addr = 32'h8000_4304;
      #1;
      check("ret_aok", 32'(bus4.addr_ok), 32'd1);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 12) begin
         @(negedge clk);
         bus4.req = 1'b0;
         lat++;
         if (bus4.data_ok) begin
            got = 1'b1;
            check("ret_rdata", bus4.rdata, 32'h0BAD_0304);
         end
      end
      check("ret_seen",    32'(got), 32'd1);
      check("ret_latency", 32'(lat), 32'd4);
      @(negedge clk);
      check("ret_pulse", 32'(bus4.data_ok), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
